// File: rtl/viterbi_frame_if.sv
// Handshake bundle between the Viterbi frame controller and its neighbours:
// coded-symbol input, BMU/PMU step control, PMU decision return and the
// decoded-bit output stream. Signal names keep their direction as seen
// from the controller.
interface viterbi_frame_if;
    logic sym_valid_i;
    logic sym_ready_o;
    logic pmu_valid_o;
    logic pmu_flush_o;
    logic drain_o;
    logic pmu_valid_i;
    logic pmu_bit_i;
    logic bit_valid_o;
    logic bit_o;
    logic bit_last_o;
    logic bit_ready_i;

    modport master (
        input  sym_valid_i,
        input  pmu_valid_i,
        input  pmu_bit_i,
        input  bit_ready_i,
        output sym_ready_o,
        output pmu_valid_o,
        output pmu_flush_o,
        output drain_o,
        output bit_valid_o,
        output bit_o,
        output bit_last_o
    );

    modport slave (
        output sym_valid_i,
        output pmu_valid_i,
        output pmu_bit_i,
        output bit_ready_i,
        input  sym_ready_o,
        input  pmu_valid_o,
        input  pmu_flush_o,
        input  drain_o,
        input  bit_valid_o,
        input  bit_o,
        input  bit_last_o
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller for a Viterbi decoder. Sequences one frame as
// flush -> accept frame_len symbols -> TB_DEPTH zero-metric drain steps,
// collects the PMU decisions of the decode steps (index >= TB_DEPTH) into a
// 2-entry output FIFO and streams them out. Steps are only issued while the
// FIFO plus the one possible in-flight decision still has room, so no
// decoded bit can ever be dropped.
module viterbi_frame_ctrl #(
    parameter int TB_DEPTH = 61,
    parameter int LEN_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic             abort_i,
    viterbi_frame_if.master  bus,
    output logic             busy_o,
    output logic             err_o
);
    // One extra bit so frame_len + TB_DEPTH never wraps.
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e           state_r;
    state_e           state_nxt_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic [CNT_W-1:0] step_inc_s;
    logic [1:0]       fifo_mem_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       fifo_cnt_r;
    logic             inflight_r;
    logic             abort_flush_r;
    logic             err_r;

    logic active_s;
    logic abort_s;
    logic credit_s;
    logic sym_ready_s;
    logic run_fire_s;
    logic drain_fire_s;
    logic step_fire_s;
    logic decode_s;
    logic push_s;
    logic pop_s;
    logic fifo_nempty_s;
    logic start_ok_s;
    logic start_err_s;

    assign active_s      = (state_r != ST_IDLE);
    // Abort outranks everything else in its cycle: no step, no push, no start.
    assign abort_s       = abort_i && active_s;
    assign fifo_nempty_s = (fifo_cnt_r != 2'd0);
    assign credit_s      = (({1'b0, fifo_cnt_r} + {2'b00, inflight_r}) < 3'd2);
    assign sym_ready_s   = (state_r == ST_RUN) && credit_s && !abort_s;
    assign run_fire_s    = sym_ready_s && bus.sym_valid_i;
    assign drain_fire_s  = (state_r == ST_DRAIN) && credit_s && !abort_s;
    assign step_fire_s   = run_fire_s || drain_fire_s;
    assign step_inc_s    = step_cnt_r + ONE_C;
    assign decode_s      = step_fire_s && (step_cnt_r >= DEPTH_C);
    // A decision is only accepted when a decode step is waiting for it.
    assign push_s        = bus.pmu_valid_i && inflight_r && !abort_s;
    assign pop_s         = fifo_nempty_s && bus.bit_ready_i;
    assign start_ok_s    = (state_r == ST_IDLE) && start_i && (frame_len_i != {LEN_W{1'b0}});
    assign start_err_s   = start_i && !abort_s &&
                           (active_s || (frame_len_i == {LEN_W{1'b0}}));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort overrides whatever the current state wants.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (run_fire_s && (step_inc_s == len_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_fire_s && (step_inc_s == (len_r + DEPTH_C))) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if ((out_cnt_r == len_r) && !fifo_nempty_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (abort_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Frame counters, in-flight tracking, output FIFO and status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_r         <= {CNT_W{1'b0}};
            step_cnt_r    <= {CNT_W{1'b0}};
            out_cnt_r     <= {CNT_W{1'b0}};
            fifo_mem_r    <= 2'b00;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            inflight_r    <= 1'b0;
            abort_flush_r <= 1'b0;
            err_r         <= 1'b0;
        end else if (abort_s) begin
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            inflight_r    <= 1'b0;
            abort_flush_r <= 1'b1;
            err_r         <= 1'b0;
        end else begin
            abort_flush_r <= 1'b0;
            err_r         <= start_err_s;
            if (start_ok_s) begin
                len_r      <= {1'b0, frame_len_i};
                step_cnt_r <= {CNT_W{1'b0}};
                out_cnt_r  <= {CNT_W{1'b0}};
            end else begin
                if (step_fire_s) begin
                    step_cnt_r <= step_inc_s;
                end
                if (pop_s) begin
                    out_cnt_r <= out_cnt_r + ONE_C;
                end
            end
            // A new decode step may be issued in the cycle its predecessor returns.
            if (decode_s) begin
                inflight_r <= 1'b1;
            end else if (push_s) begin
                inflight_r <= 1'b0;
            end
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.pmu_bit_i;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign bus.sym_ready_o = sym_ready_s;
    assign bus.pmu_valid_o = step_fire_s;
    assign bus.drain_o     = drain_fire_s;
    assign bus.pmu_flush_o = (state_r == ST_FLUSH) || abort_flush_r;
    assign bus.bit_valid_o = fifo_nempty_s;
    assign bus.bit_o       = fifo_nempty_s && fifo_mem_r[rd_ptr_r];
    assign bus.bit_last_o  = fifo_nempty_s && (out_cnt_r == (len_r - ONE_C));
    assign busy_o          = active_s;
    assign err_o           = err_r;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench for viterbi_frame_ctrl. A small PMU model answers every
// step one cycle later; for decode steps it returns bit (step - DEPTH) of
// frame_data, so the decoded stream must reproduce frame_data in order.
module tb_viterbi_frame_ctrl;
    localparam int DEPTH = 61;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic             abort_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             busy_o;
    logic             err_o;

    viterbi_frame_if bus();

    viterbi_frame_ctrl #(.TB_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .frame_len_i (frame_len_i),
        .abort_i     (abort_i),
        .bus         (bus),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [127:0] frame_data = 128'd0;

    // Monitor / PMU model state (written only by the monitor process).
    int step_seen = 0;
    int pend      = 0;
    int max_pend  = 0;
    int n_step    = 0;
    int n_drain   = 0;
    int n_hs      = 0;
    int n_flush   = 0;
    int n_bad     = 0;
    bit bit_q[$];
    bit last_q[$];

    // Monitor on the falling edge, PMU response driven just after the rising edge.
    initial begin
        logic resp_v;
        logic resp_b;
        bus.pmu_valid_i = 1'b0;
        bus.pmu_bit_i   = 1'b0;
        forever begin
            @(negedge clk);
            resp_v = 1'b0;
            resp_b = 1'b0;
            if (bus.pmu_flush_o) begin
                step_seen = 0;
                pend      = 0;
                max_pend  = 0;
                n_flush++;
            end
            if (bus.bit_valid_o && bus.bit_ready_i) begin
                bit_q.push_back(bus.bit_o);
                last_q.push_back(bus.bit_last_o);
                pend--;
            end
            if (bus.sym_valid_i && bus.sym_ready_o) n_hs++;
            if (bus.pmu_valid_o) begin
                n_step++;
                if (bus.drain_o) n_drain++;
                else if (!(bus.sym_valid_i && bus.sym_ready_o)) n_bad++;
                if (bus.drain_o && bus.sym_ready_o) n_bad++;
                resp_v = 1'b1;
                if (step_seen >= DEPTH) begin
                    resp_b = frame_data[step_seen - DEPTH];
                    pend++;
                end else begin
                    resp_b = step_seen[0];
                end
                step_seen++;
            end else if (bus.drain_o) begin
                n_bad++;
            end
            if (pend > max_pend) max_pend = pend;
            @(posedge clk);
            #1;
            bus.pmu_valid_i = resp_v;
            bus.pmu_bit_i   = resp_b;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len);
        frame_len_i = len;
        start_i     = 1'b1;
        tick();
        start_i     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit to);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        to = busy_o;
    endtask

    task automatic collect(input int b0, input int len,
                           output logic [127:0] bits, output logic [127:0] lasts);
        bits  = 128'd0;
        lasts = 128'd0;
        for (int k = 0; k < len; k++) begin
            if (b0 + k < bit_q.size()) begin
                bits[k]  = bit_q[b0 + k];
                lasts[k] = last_q[b0 + k];
            end else begin
                bits[k]  = 1'bx;
                lasts[k] = 1'bx;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus.sym_ready_o, bus.pmu_valid_o, bus.pmu_flush_o, bus.drain_o, bus.bit_valid_o,
             bus.bit_o, bus.bit_last_o, busy_o, err_o} !== 9'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", {bus.sym_ready_o, bus.pmu_valid_o,
                     bus.pmu_flush_o, bus.drain_o, bus.bit_valid_o, bus.bit_o, bus.bit_last_o,
                     busy_o, err_o}, 9'b0);
        end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        checks++;
        if ({busy_o, err_o, bus.bit_valid_o, bus.sym_ready_o, bus.pmu_flush_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b",
                     {busy_o, err_o, bus.bit_valid_o, bus.sym_ready_o, bus.pmu_flush_o}, 5'b0);
        end
    endtask

    task automatic test_nominal();
        logic [127:0] gb, gl;
        bit to;
        int s0, d0, h0, f0, b0, x0;
        frame_data = 128'hB;
        bus.sym_valid_i = 1'b1;
        bus.bit_ready_i = 1'b1;
        s0 = n_step; d0 = n_drain; h0 = n_hs; f0 = n_flush; b0 = bit_q.size(); x0 = n_bad;
        start_frame(16'd4);
        checks++;
        if ({busy_o, bus.pmu_flush_o} !== 2'b11) begin
            failures++;
            $display("FAIL nom_flush got=%b exp=%b", {busy_o, bus.pmu_flush_o}, 2'b11);
        end
        tick();
        checks++;
        if ({bus.pmu_flush_o, bus.sym_ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL nom_run_entry got=%b exp=%b", {bus.pmu_flush_o, bus.sym_ready_o}, 2'b01);
        end
        wait_idle(600, to);
        collect(b0, 4, gb, gl);
        checks++;
        if (to) begin failures++; $display("FAIL nom_timeout got=busy exp=idle"); end
        checks++;
        if (n_flush - f0 !== 1) begin failures++; $display("FAIL nom_flush_cycles got=%0d exp=1", n_flush - f0); end
        checks++;
        if (n_hs - h0 !== 4) begin failures++; $display("FAIL nom_symbols got=%0d exp=4", n_hs - h0); end
        checks++;
        if (n_drain - d0 !== 61) begin failures++; $display("FAIL nom_drain got=%0d exp=61", n_drain - d0); end
        checks++;
        if (n_step - s0 !== 65) begin failures++; $display("FAIL nom_steps got=%0d exp=65", n_step - s0); end
        checks++;
        if (bit_q.size() - b0 !== 4) begin failures++; $display("FAIL nom_bit_count got=%0d exp=4", bit_q.size() - b0); end
        checks++;
        if (gb[3:0] !== 4'b1011) begin failures++; $display("FAIL nom_bits got=%b exp=%b", gb[3:0], 4'b1011); end
        checks++;
        if (gl[3:0] !== 4'b1000) begin failures++; $display("FAIL nom_last got=%b exp=%b", gl[3:0], 4'b1000); end
        checks++;
        if (n_bad - x0 !== 0) begin failures++; $display("FAIL nom_bad_steps got=%0d exp=0", n_bad - x0); end
    endtask

    task automatic test_len1();
        logic [127:0] gb, gl;
        bit to;
        int s0, b0;
        frame_data = 128'h1;
        s0 = n_step; b0 = bit_q.size();
        start_frame(16'd1);
        wait_idle(300, to);
        collect(b0, 1, gb, gl);
        checks++;
        if (to || (bit_q.size() - b0 !== 1)) begin
            failures++; $display("FAIL len1_count got=%0d exp=1 timeout=%0d", bit_q.size() - b0, to);
        end
        checks++;
        if ({gb[0], gl[0]} !== 2'b11) begin failures++; $display("FAIL len1_bit_last got=%b exp=11", {gb[0], gl[0]}); end
        checks++;
        if (n_step - s0 !== 62) begin failures++; $display("FAIL len1_steps got=%0d exp=62", n_step - s0); end
    endtask

    task automatic test_backpressure();
        logic [127:0] gb, gl, mask;
        bit to;
        int s0, b0, n;
        frame_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        mask = (128'd1 << 70) - 128'd1;
        bus.sym_valid_i = 1'b1;
        bus.bit_ready_i = 1'b1;
        s0 = n_step; b0 = bit_q.size();
        start_frame(16'd70);
        n = 0;
        while ((n_step - s0 < 63) && n < 400) begin
            tick();
            n++;
        end
        bus.bit_ready_i = 1'b0;
        repeat (10) tick();
        checks++;
        if ({busy_o, bus.bit_valid_o, bus.sym_ready_o, bus.pmu_valid_o} !== 4'b1100) begin
            failures++;
            $display("FAIL bp_stall got=%b exp=%b",
                     {busy_o, bus.bit_valid_o, bus.sym_ready_o, bus.pmu_valid_o}, 4'b1100);
        end
        bus.bit_ready_i = 1'b1;
        wait_idle(1500, to);
        collect(b0, 70, gb, gl);
        checks++;
        if (to || (bit_q.size() - b0 !== 70)) begin
            failures++; $display("FAIL bp_count got=%0d exp=70 timeout=%0d", bit_q.size() - b0, to);
        end
        checks++;
        if (gb !== (frame_data & mask)) begin failures++; $display("FAIL bp_bits got=%h exp=%h", gb, frame_data & mask); end
        checks++;
        if (gl !== (128'd1 << 69)) begin failures++; $display("FAIL bp_last got=%h exp=%h", gl, 128'd1 << 69); end
        checks++;
        if (n_step - s0 !== 131) begin failures++; $display("FAIL bp_steps got=%0d exp=131", n_step - s0); end
        checks++;
        if (max_pend > 2) begin failures++; $display("FAIL bp_occupancy got=%0d exp<=2", max_pend); end
    endtask

    task automatic test_gaps();
        logic [127:0] gb, gl;
        logic [15:0] pat;
        bit to;
        int s0, h0, b0, x0, n;
        pat = 16'b1010_0110_0011_0101;
        frame_data = 128'h15;
        bus.sym_valid_i = 1'b0;
        bus.bit_ready_i = 1'b1;
        s0 = n_step; h0 = n_hs; b0 = bit_q.size(); x0 = n_bad;
        start_frame(16'd5);
        n = 0;
        while (busy_o && n < 600) begin
            bus.sym_valid_i = pat[n % 16];
            tick();
            n++;
        end
        to = busy_o;
        bus.sym_valid_i = 1'b0;
        collect(b0, 5, gb, gl);
        checks++;
        if (to) begin failures++; $display("FAIL gaps_timeout got=busy exp=idle"); end
        checks++;
        if (n_hs - h0 !== 5) begin failures++; $display("FAIL gaps_symbols got=%0d exp=5", n_hs - h0); end
        checks++;
        if (n_step - s0 !== 66) begin failures++; $display("FAIL gaps_steps got=%0d exp=66", n_step - s0); end
        checks++;
        if (n_bad - x0 !== 0) begin failures++; $display("FAIL gaps_stray_steps got=%0d exp=0", n_bad - x0); end
        checks++;
        if ((bit_q.size() - b0 !== 5) || (gb[4:0] !== 5'b10101)) begin
            failures++; $display("FAIL gaps_bits got=%b exp=%b count=%0d", gb[4:0], 5'b10101, bit_q.size() - b0);
        end
    endtask

    task automatic test_errors();
        logic [127:0] gb, gl;
        bit to;
        int s0, b0;
        bus.sym_valid_i = 1'b1;
        bus.bit_ready_i = 1'b1;
        start_frame(16'd0);
        checks++;
        if ({err_o, busy_o} !== 2'b10) begin failures++; $display("FAIL err_zero_len got=%b exp=10", {err_o, busy_o}); end
        tick();
        checks++;
        if ({err_o, busy_o} !== 2'b00) begin failures++; $display("FAIL err_zero_len_pulse got=%b exp=00", {err_o, busy_o}); end
        frame_data = 128'h2;
        s0 = n_step; b0 = bit_q.size();
        start_frame(16'd3);
        tick();
        frame_len_i = 16'd9;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if ({err_o, busy_o} !== 2'b11) begin failures++; $display("FAIL err_busy_start got=%b exp=11", {err_o, busy_o}); end
        tick();
        checks++;
        if (err_o !== 1'b0) begin failures++; $display("FAIL err_busy_pulse got=%b exp=0", err_o); end
        wait_idle(400, to);
        collect(b0, 3, gb, gl);
        checks++;
        if (to || (bit_q.size() - b0 !== 3) || (gb[2:0] !== 3'b010)) begin
            failures++; $display("FAIL err_frame_bits got=%b exp=010 count=%0d", gb[2:0], bit_q.size() - b0);
        end
        checks++;
        if (n_step - s0 !== 64) begin failures++; $display("FAIL err_frame_steps got=%0d exp=64", n_step - s0); end
    endtask

    task automatic test_abort();
        logic [127:0] gb, gl;
        bit to;
        int s0, d0, b0, n;
        frame_data = 128'h5;
        bus.sym_valid_i = 1'b1;
        bus.bit_ready_i = 1'b0;
        d0 = n_drain;
        start_frame(16'd3);
        n = 0;
        while (!bus.bit_valid_o && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (!(bus.bit_valid_o === 1'b1 && busy_o === 1'b1 && (n_drain - d0) >= 1 && (n_drain - d0) < 61)) begin
            failures++;
            $display("FAIL abort_setup got=valid%b busy%b drains%0d exp=valid1 busy1 drains1..60",
                     bus.bit_valid_o, busy_o, n_drain - d0);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if ({busy_o, bus.bit_valid_o, bus.pmu_flush_o} !== 3'b001) begin
            failures++; $display("FAIL abort_next got=%b exp=001", {busy_o, bus.bit_valid_o, bus.pmu_flush_o});
        end
        tick();
        checks++;
        if ({busy_o, bus.bit_valid_o, bus.pmu_flush_o} !== 3'b000) begin
            failures++; $display("FAIL abort_flush_pulse got=%b exp=000", {busy_o, bus.bit_valid_o, bus.pmu_flush_o});
        end
        frame_data = 128'h6;
        bus.bit_ready_i = 1'b1;
        s0 = n_step; b0 = bit_q.size();
        start_frame(16'd3);
        wait_idle(400, to);
        collect(b0, 3, gb, gl);
        checks++;
        if (to || (bit_q.size() - b0 !== 3)) begin
            failures++; $display("FAIL abort_new_count got=%0d exp=3 timeout=%0d", bit_q.size() - b0, to);
        end
        checks++;
        if ({gb[2:0], gl[2:0]} !== 6'b110_100) begin
            failures++; $display("FAIL abort_new_bits got=%b exp=%b", {gb[2:0], gl[2:0]}, 6'b110_100);
        end
        checks++;
        if (n_step - s0 !== 64) begin failures++; $display("FAIL abort_new_steps got=%0d exp=64", n_step - s0); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] gb, gl;
        bit to;
        int s0, b0;
        frame_data = 128'h9;
        bus.sym_valid_i = 1'b1;
        bus.bit_ready_i = 1'b1;
        start_frame(16'd4);
        tick();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.sym_ready_o, bus.pmu_valid_o, bus.pmu_flush_o, bus.drain_o, bus.bit_valid_o,
             bus.bit_o, bus.bit_last_o, busy_o, err_o} !== 9'b0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b exp=%b", {bus.sym_ready_o, bus.pmu_valid_o,
                     bus.pmu_flush_o, bus.drain_o, bus.bit_valid_o, bus.bit_o, bus.bit_last_o,
                     busy_o, err_o}, 9'b0);
        end
        tick();
        #2;
        rst_ni = 1'b1;
        tick();
        frame_data = 128'h6;
        s0 = n_step; b0 = bit_q.size();
        start_frame(16'd4);
        wait_idle(400, to);
        collect(b0, 4, gb, gl);
        checks++;
        if (to || (bit_q.size() - b0 !== 4)) begin
            failures++; $display("FAIL rstmid_count got=%0d exp=4 timeout=%0d", bit_q.size() - b0, to);
        end
        checks++;
        if ({gb[3:0], gl[3:0]} !== 8'b0110_1000) begin
            failures++; $display("FAIL rstmid_bits got=%b exp=%b", {gb[3:0], gl[3:0]}, 8'b0110_1000);
        end
        checks++;
        if (n_step - s0 !== 65) begin failures++; $display("FAIL rstmid_steps got=%0d exp=65", n_step - s0); end
    endtask

    initial begin
        rst_ni          = 1'b0;
        start_i         = 1'b0;
        abort_i         = 1'b0;
        frame_len_i     = 16'd0;
        bus.sym_valid_i = 1'b0;
        bus.bit_ready_i = 1'b0;
        test_reset();
        test_nominal();
        test_len1();
        test_backpressure();
        test_gaps();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
